// File: rtl/inv_n.sv
// inv_n: bitwise inverter with a zero-latency combinational output and a
// LATENCY-deep registered copy carrying a valid flag and a change pulse.
module inv_n #(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_y_q,
   output logic             o_vld,
   output logic             o_chg
);

   // Pipeline stage 0 holds the newest word; stage LATENCY-1 drives the outputs.
   logic [WIDTH-1:0]   data_q [LATENCY];
   logic [WIDTH-1:0]   data_d [LATENCY];
   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] vld_d;
   logic [LATENCY-1:0] chg_q;
   logic [LATENCY-1:0] chg_d;
   logic [WIDTH-1:0]   x_prev_q;
   logic [WIDTH-1:0]   x_prev_d;

   // Glue-logic path: pure NOT, independent of clock and reset.
   assign o_y = ~i_x;

   // Next-state: load stage 0 from the input, shift every later stage along.
   // vld_q[0] doubles as the first-sample qualifier: it is still 0 on the
   // first edge after reset, so the compare against the reset x_prev is masked.
   always_comb begin
      x_prev_d  = i_x;
      data_d[0] = ~i_x;
      vld_d[0]  = 1'b1;
      chg_d[0]  = (i_x != x_prev_q) && vld_q[0];
      for (int i = 1; i < LATENCY; i++) begin
         data_d[i] = data_q[i-1];
         vld_d[i]  = vld_q[i-1];
         chg_d[i]  = chg_q[i-1];
      end
   end

   // State registers; reset loads the inverse of an all-zero word and clears flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= {WIDTH{1'b1}};
         end
         vld_q    <= '0;
         chg_q    <= '0;
         x_prev_q <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) begin
            data_q[i] <= data_d[i];
         end
         vld_q    <= vld_d;
         chg_q    <= chg_d;
         x_prev_q <= x_prev_d;
      end
   end

   assign o_y_q = data_q[LATENCY-1];
   assign o_vld = vld_q[LATENCY-1];
   assign o_chg = chg_q[LATENCY-1];

endmodule

// File: tb/tb_inv_n.sv
// Directed testbench for inv_n: four instances cover WIDTH 4/1/32 and LATENCY 1/2/3.
module tb_inv_n;

   logic        clk;
   logic        run;
   logic        rst_n;
   logic [3:0]  x4;
   logic [0:0]  x1;
   logic [31:0] x32;

   logic [3:0]  a_y, a_yq, b_y, b_yq;
   logic        a_vld, a_chg, b_vld, b_chg;
   logic [0:0]  c_y, c_yq;
   logic        c_vld, c_chg;
   logic [31:0] d_y, d_yq;
   logic        d_vld, d_chg;

   int checks;
   int errors;

   inv_n #(.WIDTH(4), .LATENCY(2)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x4),
      .o_y(a_y), .o_y_q(a_yq), .o_vld(a_vld), .o_chg(a_chg));

   inv_n #(.WIDTH(4), .LATENCY(1)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x4),
      .o_y(b_y), .o_y_q(b_yq), .o_vld(b_vld), .o_chg(b_chg));

   inv_n #(.WIDTH(1), .LATENCY(1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x1),
      .o_y(c_y), .o_y_q(c_yq), .o_vld(c_vld), .o_chg(c_chg));

   inv_n #(.WIDTH(32), .LATENCY(3)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x32),
      .o_y(d_y), .o_y_q(d_yq), .o_vld(d_vld), .o_chg(d_chg));

   // Gated clock so the combinational check runs with no clock at all.
   initial clk = 1'b0;
   always begin
      #5;
      if (run) clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      run    = 1'b0;
      x4     = 4'd0;
      x1     = 1'b0;
      x32    = 32'd0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #1;

      // Reset values with the clock stopped.
      chk("rst_yq", 32'(a_yq), 32'hF);
      chk("rst_vld", 32'(a_vld), 32'd0);
      chk("rst_chg", 32'(a_chg), 32'd0);
      chk("rst_d_yq", d_yq, 32'hFFFF_FFFF);

      // Exhaustive combinational check while reset is held, clock stopped.
      for (int i = 0; i < 16; i++) begin
         logic [3:0] e;
         x4 = 4'(i);
         e  = 4'(~x4);
         #1;
         chk($sformatf("comb_%0d", i), 32'(a_y), 32'(e));
         chk($sformatf("rst_hold_yq_%0d", i), 32'(a_yq), 32'hF);
      end

      // Latency check: release with 0011 held.
      x4  = 4'b0011;
      run = 1'b1;
      step();
      rst_n = 1'b1;
      step();                                   // edge 1
      chk("lat_e1_vld", 32'(a_vld), 32'd0);
      chk("lat_e1_yq", 32'(a_yq), 32'hF);
      chk("lat_e1_b_vld", 32'(b_vld), 32'd1);
      chk("lat_e1_b_yq", 32'(b_yq), 32'hC);
      step();                                   // edge 2
      chk("lat_e2_vld", 32'(a_vld), 32'd1);
      chk("lat_e2_yq", 32'(a_yq), 32'hC);
      chk("lat_e2_chg", 32'(a_chg), 32'd0);
      step();                                   // edge 3
      chk("lat_e3_chg", 32'(a_chg), 32'd0);
      chk("lat_e3_b_chg", 32'(b_chg), 32'd0);

      // Counting data, then reset asserted between edges.
      for (int i = 0; i < 3; i++) begin
         x4 = 4'(i + 5);
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_yq", 32'(a_yq), 32'hF);
      chk("mid_vld", 32'(a_vld), 32'd0);
      chk("mid_chg", 32'(a_chg), 32'd0);
      chk("mid_b_yq", 32'(b_yq), 32'hF);
      chk("mid_b_vld", 32'(b_vld), 32'd0);

      // Change pulse sequence 0001,0001,0110,0110 from a fresh release.
      x4 = 4'b0001;
      step();
      rst_n = 1'b1;
      step();                                   // edge 1
      chk("chg_e1_b_yq", 32'(b_yq), 32'hE);
      chk("chg_e1_b_chg", 32'(b_chg), 32'd0);
      chk("rec_e1_a_vld", 32'(a_vld), 32'd0);
      step();                                   // edge 2
      chk("chg_e2_b_chg", 32'(b_chg), 32'd0);
      chk("rec_e2_a_vld", 32'(a_vld), 32'd1);
      chk("rec_e2_a_yq", 32'(a_yq), 32'hE);
      x4 = 4'b0110;
      step();                                   // edge 3
      chk("chg_e3_b_yq", 32'(b_yq), 32'h9);
      chk("chg_e3_b_chg", 32'(b_chg), 32'd1);
      chk("chg_e3_a_chg", 32'(a_chg), 32'd0);
      step();                                   // edge 4
      chk("chg_e4_b_chg", 32'(b_chg), 32'd0);
      chk("chg_e4_a_chg", 32'(a_chg), 32'd1);
      chk("chg_e4_a_yq", 32'(a_yq), 32'h9);
      step();                                   // edge 5
      chk("chg_e5_a_chg", 32'(a_chg), 32'd0);

      // WIDTH=1: both values, combinational and registered.
      for (int v = 0; v < 2; v++) begin
         x1 = 1'(v);
         #1;
         chk($sformatf("w1_y_%0d", v), 32'(c_y), 32'(1 - v));
         step();
         chk($sformatf("w1_yq_%0d", v), 32'(c_yq), 32'(1 - v));
      end

      // WIDTH=32, LATENCY=3: exact latency on an all-ones word.
      x32 = 32'd0;
      step(); step(); step();
      x32 = 32'hFFFF_FFFF;
      #1;
      chk("w32_y_ones", d_y, 32'd0);
      step(); step();
      chk("w32_yq_e2_old", d_yq, 32'hFFFF_FFFF);
      step();
      chk("w32_yq_e3_new", d_yq, 32'd0);

      // WIDTH=32 walking one.
      for (int k = 0; k < 32; k++) begin
         x32 = 32'd1 << k;
         #1;
         chk($sformatf("w32_y_walk_%0d", k), d_y, ~(32'd1 << k));
         step(); step(); step();
         chk($sformatf("w32_yq_walk_%0d", k), d_yq, ~(32'd1 << k));
      end
      chk("w32_vld", 32'(d_vld), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
